// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_event_gen
// Purpose  : Synchronizes and debounces the push-buttons; emits clean levels
//            and one-cycle press/release pulses. KEY_REPEAT_EN adds auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_gen #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                MAX10_CLK1_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic                any_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Pending entry already consumes one stable sample, so the change is
    // accepted when the count reaches DEBOUNCE_CYCLES-2.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_PEND = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_PEND   = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_event_gen: illegal parameter set");
    end

    logic [NUM_KEYS-1:0] w_press_nxt_vec;
    logic                r_any_press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [1:0]         r_sync;
        logic               w_s;
        state_t             r_state;
        state_t             w_state_nxt;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        logic [c_CNT_W-1:0] w_cnt_inc;
        logic               w_press_nxt;
        logic               w_rel_nxt;
        logic               w_level_nxt;
        logic               w_rpt_hit;
        logic               r_level;
        logic               r_press;
        logic               r_rel;

        // Two-flop synchronizer; reset value models a released key.
        always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_sync <= 2'b11;
            end else begin
                r_sync <= {r_sync[0], KEY[i]};
            end
        end

        assign w_s       = r_sync[1];
        assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_press_nxt = 1'b0;
            w_rel_nxt   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_s) begin
                        w_state_nxt = ST_PRESS_PEND;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESS_PEND: begin
                    if (w_s) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (w_s) begin
                        w_state_nxt = ST_REL_PEND;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_press_nxt = w_rpt_hit;
                    end
                end
                ST_REL_PEND: begin
                    if (!w_s) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_rel_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REL_PEND);

        always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_press <= w_press_nxt;
                r_rel   <= w_rel_nxt;
            end
        end

`ifdef KEY_REPEAT_EN
        localparam int c_RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int c_RPT_W    = $clog2(c_RPT_SPAN + 1);
        localparam logic [c_RPT_W-1:0] c_RPT_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
        localparam logic [c_RPT_W-1:0] c_RPT_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);
        localparam logic [c_RPT_W-1:0] c_RPT_MAX         = {c_RPT_W{1'b1}};

        logic [c_RPT_W-1:0] r_rpt_cnt;
        logic               r_rpt_armed;
        logic               w_stay_held;

        // The counter only advances while HELD is kept; any exit (including
        // a rejected release bounce) restarts the initial delay.
        assign w_stay_held = (r_state == ST_HELD) && !w_s;
        assign w_rpt_hit   = w_stay_held &&
                             (r_rpt_armed ? (r_rpt_cnt == c_RPT_PERIOD_LAST)
                                          : (r_rpt_cnt == c_RPT_DELAY_LAST));

        always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b0;
            end else if (!w_stay_held) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b0;
            end else if (w_rpt_hit) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b1;
            end else if (r_rpt_cnt != c_RPT_MAX) begin
                r_rpt_cnt <= r_rpt_cnt + c_RPT_W'(1);
            end
        end
`else
        assign w_rpt_hit = 1'b0;
`endif

        assign w_press_nxt_vec[i] = w_press_nxt;
        assign key_level[i]       = r_level;
        assign press_pulse[i]     = r_press;
        assign release_pulse[i]   = r_rel;
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_nxt_vec;
        end
    end

    assign any_press = r_any_press;

endmodule
`default_nettype wire

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Input-side conditioner for the board push-buttons (KEY[1:0], active-low, bouncy, asynchronous).
- Synchronizes, debounces and converts each key into a clean level plus single-cycle press/release event pulses.
- Game and state-machine logic consume these events instead of sampling raw KEY levels.
- Sits between the KEY pins and all game logic in the top level, one instance covering all keys.

Parameters:
- NUM_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles required to accept a change (10 ms at 50 MHz); legal minimum 2.
- REPEAT_DELAY, 25000000, hold time before the first auto-repeat pulse (KEY_REPEAT_EN only).
- REPEAT_PERIOD, 5000000, interval between subsequent auto-repeat pulses (KEY_REPEAT_EN only).

Ports:
- MAX10_CLK1_50  input  1  system clock, 50 MHz; all logic on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY  input  NUM_KEYS  raw push-buttons; 0 = pressed.
- key_level  output  NUM_KEYS  debounced state; 1 = pressed.
- press_pulse  output  NUM_KEYS  one-cycle high on accepted press (and on auto-repeat when enabled).
- release_pulse  output  NUM_KEYS  one-cycle high on accepted release.
- any_press  output  1  OR of press_pulse, same cycle.

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0.
  - Both synchronizer flops per key go to 1 (released).
  - Every channel FSM goes to IDLE; all counters go to 0.
- Synchronizer: two flops per key. FSM acts only on stage-2 output `s`; nothing else reads raw KEY.
- Per-key FSM; channels are fully independent.
- IDLE (key_level=0):
  - If s==0, go to PRESS_PEND with cnt=0.
- PRESS_PEND:
  - If s==1, return to IDLE with no pulse (bounce rejected).
  - Otherwise cnt++.
  - When cnt==DEBOUNCE_CYCLES-1 and s==0, go to HELD: key_level=1 and press_pulse=1 for exactly one cycle.
- HELD (key_level=1):
  - If s==1, go to REL_PEND with cnt=0.
- REL_PEND:
  - If s==0, return to HELD with no pulse.
  - At cnt==DEBOUNCE_CYCLES-1 with s==1, go to IDLE: key_level=0 and release_pulse=1 for exactly one cycle.
- Latency and timing:
  - Let edge 0 be the edge where s first changes. The FSM enters the pending state at edge 1.
  - Outputs update at edge DEBOUNCE_CYCLES when the input was stable throughout.
  - Add 2 edges of synchronizer delay from the raw pin.
- Counter width is clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps. It clears on every state transition.
- press_pulse and release_pulse are never high together on the same key. Pulses on different keys may coincide; any_press is then 1 for one cycle.
- Reset mid-operation:
  - Pending counts are discarded and no pulse is produced.
  - A key held through reset deassertion is treated as a new press: it is debounced from IDLE and emits press_pulse.
- All outputs are registered; there are no combinational paths from KEY.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter that runs only in HELD and clears on any exit from HELD.
  - Extra press_pulse at REPEAT_DELAY cycles after HELD entry, then every REPEAT_PERIOD cycles while still HELD.
  - Repeat pulses also drive any_press.
  - release_pulse is unaffected.
  - Going HELD→REL_PEND→HELD (rejected release bounce) restarts the repeat delay.
- Undefined:
  - No repeat counter logic is built; REPEAT_* parameters are ignored.
  - press_pulse fires exactly once per accepted press.

Test Plan:
- DEBOUNCE_CYCLES=8: reset, hold KEY=2'b11, then KEY[0]=0 steady → press_pulse[0] high 1 cycle at edge 10 after the raw change (2 sync + 8); key_level[0]=1; no pulse on key 1.
- KEY[0] bounces: low 5 cycles, high 2, low 3, high → no press_pulse, key_level stays 0; then low 20 cycles → exactly one press_pulse.
- Release after HELD with a 3-cycle low glitch during REL_PEND → no release_pulse until 8 stable high cycles, then release_pulse[0] for 1 cycle, key_level[0]=0.
- Both keys pressed on the same edge → press_pulse=2'b11 for one cycle and any_press=1 for that cycle only.
- Assert RESET_N=0 while KEY[1] is in PRESS_PEND (cnt=5), keep key held, deassert → outputs 0 during reset, no pulse, then press_pulse[1] after a full 10-edge debounce.
- KEY_REPEAT_EN with DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10, hold 100 cycles after HELD → press_pulse at HELD entry, +40, +50, +60, +70, +80, +90, +100; without the macro → only the first pulse.
